// File: rtl/mult_pkg.sv
// Shared types and elaboration-time helpers for the iterative multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic bit params_ok(input int unsigned width, input int unsigned bpc);
        return (width >= 4) && ((width % 2) == 0) &&
               ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
               ((width % bpc) == 0);
    endfunction

    // Number of compute iterations needed to consume the whole multiplier.
    function automatic int unsigned n_iter(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Splits an operand into unsigned magnitude and a sign flag; ns=1 means the value is unsigned.
module mult_sign_fix #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         ns_i,
    output logic [W-1:0] mag_c_o,
    output logic         neg_c_o
);

    assign neg_c_o = ~ns_i & val_i[W-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_c_o = neg_c_o ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier, BPC multiplier bits per clock, valid/ready on both sides.
module mult_iter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BPC   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_multa_ns,
    input  logic               i_multb_ns,
    input  logic [WIDTH-1:0]   i_multa,
    input  logic [WIDTH-1:0]   i_multb,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned N  = n_iter(WIDTH, BPC);
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (!params_ok(WIDTH, BPC)) begin : g_param_check
        $fatal(1, "mult_iter: WIDTH must be even and >= 4, BPC in {1,2,4} dividing WIDTH");
    end

    state_t          state_q;
    logic [W2-1:0]   mplier_q;
    logic [WIDTH-1:0] mcand_q;
    logic            neg_q;
    logic [W2-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [W2-1:0]   product_q;
    logic            ready_q;
    logic            valid_q;
    logic            busy_q;

    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic             neg_a_c;
    logic             neg_b_c;
    logic [W2-1:0]    addend_c;
    logic [W2-1:0]    acc_sum_c;
    logic [W2-1:0]    result_c;

    mult_sign_fix #(.W(WIDTH)) u_fix_a (
        .val_i   (i_multa),
        .ns_i    (i_multa_ns),
        .mag_c_o (mag_a_c),
        .neg_c_o (neg_a_c)
    );

    mult_sign_fix #(.W(WIDTH)) u_fix_b (
        .val_i   (i_multb),
        .ns_i    (i_multb_ns),
        .mag_c_o (mag_b_c),
        .neg_c_o (neg_b_c)
    );

    // mplier_q is |A| pre-shifted to the current digit position, so each
    // partial product is a sum of gated shifted copies.
    always_comb begin
        addend_c = '0;
        for (int i = 0; i < BPC; i++) begin
            if (mcand_q[i]) begin
                addend_c = addend_c + (mplier_q << i);
            end
        end
    end

    assign acc_sum_c = acc_q + addend_c;
    assign result_c  = neg_q ? (~acc_sum_c + W2'(1)) : acc_sum_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            mplier_q  <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        mplier_q <= W2'(mag_a_c);
                        mcand_q  <= mag_b_c;
                        neg_q    <= neg_a_c ^ neg_b_c;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_CALC;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_CALC: begin
                    acc_q    <= acc_sum_c;
                    mplier_q <= mplier_q << BPC;
                    mcand_q  <= mcand_q >> BPC;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        product_q <= result_c;
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_product = product_q;

endmodule

// File: doc/mult_iter.md
# mult_iter

Parametrised iterative multiplier, the successor to the fixed 16x16 multiplier wrapper. It takes two WIDTH-bit operands, each independently signed or unsigned, and produces the full 2*WIDTH-bit product. It retires BPC partial-product bits per clock through a shift-add datapath. The block sits behind a valid/ready handshake on both sides, so it can be placed between pipeline stages without external sequencing.

## Interface
- WIDTH, 16, operand width; even, >= 4
- BPC, 2, multiplier bits retired per cycle; one of 1, 2, 4; must divide WIDTH
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  operand request valid
- o_ready  out  1  block can accept operands
- i_multa_ns  in  1  operand A is unsigned (1) or two's-complement signed (0)
- i_multb_ns  in  1  operand B is unsigned (1) or two's-complement signed (0)
- i_multa  in  WIDTH  operand A
- i_multb  in  WIDTH  operand B
- o_valid  out  1  o_product valid
- i_ready  in  1  consumer accepts product
- o_product  out  2*WIDTH  product; two's complement if either operand is signed, else unsigned
- o_busy  out  1  state != IDLE

## Operation
- Derived constant: N = WIDTH/BPC, the number of compute iterations.
- States:
  - IDLE: o_ready=1.
    - i_valid=1 → capture magnitudes |A| and |B| (WIDTH-bit unsigned).
    - Capture neg = sA ^ sB, where sX = ~ns & MSB.
    - Clear accumulator and iteration counter; go to CALC.
  - CALC: each cycle, acc += (|A| * low BPC bits of mcand) << (BPC*cnt); shift mcand right by BPC; cnt++.
    - When cnt == N-1: on that edge, write the final result and go to DONE.
    - Final result is neg ? -acc : acc, truncated to 2*WIDTH bits.
  - DONE: o_valid=1; o_product stable.
    - i_ready=1 → IDLE.
    - i_ready=0 → hold in DONE indefinitely.
- Width rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits.
  - Every ns combination fits in 2*WIDTH bits, so no overflow is possible.
- Operands are captured at acceptance. Changes on i_multa/i_multb/ns after acceptance have no effect.
- i_valid while o_ready=0 is ignored; the upstream must hold it.
- Reset (at any time, including mid-CALC or in DONE) takes effect on the next edge:
  - State → IDLE.
  - o_valid=0, o_busy=0, o_ready=1.
  - o_product=0, accumulator=0, counter=0.
  - The in-flight operation is discarded.

## Timing
- Acceptance edge = edge E0 with i_valid & o_ready.
- Latency:
  - CALC occupies N cycles.
  - o_valid=1 from cycle E0+N+1, i.e. 9 cycles after acceptance with the defaults.
- o_product is registered and changes only on the CALC→DONE edge or on reset.
- Release and re-accept:
  - DONE with i_ready=1 at edge Ek → IDLE; o_ready=1 in cycle Ek+1.
  - Earliest next acceptance is edge Ek+1.
  - Maximum throughput: one product per N+2 cycles.
- o_ready, o_valid and o_busy are pure state decodes, with no combinational path from any input.

## Structure
- Package mult_pkg holds:
  - state encoding constants (IDLE, CALC, DONE);
  - parameter legality check (WIDTH even and >= 4; BPC in {1,2,4}; WIDTH % BPC == 0), failing elaboration on violation;
  - N derivation.
- Sub-module mult_sign_fix: combinational. Given a value, its ns flag and its width, returns the magnitude and sign. It is instantiated twice for the operands. The same negate logic is reused at the result stage.

## Test plan
Defaults WIDTH=16, BPC=2 unless stated.
- Unsigned max: A=0xFFFF, B=0xFFFF, both ns=1 → o_product=0xFFFE0001; o_valid rises exactly 9 cycles after acceptance.
- Signed min: A=0x8000, B=0x8000, both ns=0 → 0x40000000. Then A=0x8000 (signed), B=0x0001 (signed) → 0xFFFF8000.
- Mixed: A=0xFFFF ns=1, B=0xFFFF ns=0 → 0xFFFF0001 (−65535).
- Backpressure: hold i_ready=0 for 20 cycles in DONE → o_valid and o_product stable, o_ready=0, and a new i_valid is ignored. Release → o_ready=1 the next cycle, then back-to-back random pairs are checked against a reference model.
- Reset mid-op: assert i_rst for 1 cycle at CALC cycle 4 → next cycle all outputs at reset values. A fresh 3*(−5) (signed) then yields 0xFFFFFFF1.
- Sweep: WIDTH ∈ {4, 8, 32}, BPC ∈ {1, 2, 4}, with exhaustive coverage at WIDTH=4. Every result is checked, and latency = WIDTH/BPC + 1 in every configuration.
